seq_lock_ctrl: RTL and testbench



---
 rtl/seq_lock_ctrl_if.sv | 28 ++
 rtl/seq_lock_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_seq_lock_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_lock_ctrl_if.sv
// Configuration bus for seq_lock_ctrl: pattern-table entry writes and
// active-length writes, driven by the master and consumed by the controller.
interface seq_lock_ctrl_if #(
  parameter int IN_W  = 4,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  // Strobe semantics, no backpressure: cfg_we / cfg_len_we are one-cycle
  // write strobes qualified by their data fields in the same cycle; the
  // controller accepts them only while it is IDLE and silently drops them
  // otherwise, so there is no ready signal.
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [IN_W-1:0] cfg_mask;
  logic [IN_W-1:0] cfg_val;
  logic            cfg_len_we;
  logic [LW-1:0]   cfg_len;

  modport master (
    output cfg_we, cfg_addr, cfg_mask, cfg_val, cfg_len_we, cfg_len
  );

  modport slave (
    input cfg_we, cfg_addr, cfg_mask, cfg_val, cfg_len_we, cfg_len
  );
endinterface

// File: rtl/seq_lock_ctrl.sv
// Table-driven input-sequence lock controller with step timeout and lockout.
// Define SEQ_LOCK_SYNC_EN to put a 2-flop synchronizer ahead of the sample register.
module seq_lock_ctrl #(
  parameter int IN_W           = 4,
  parameter int DEPTH          = 16,
  parameter int STEP_TIMEOUT   = 1000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 5000,
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW  = AW + 1,
  localparam int FW  = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1,
  localparam int TW  = $clog2(STEP_TIMEOUT + 1),
  localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                clear,
  input  logic [IN_W-1:0]     in_vec,
  seq_lock_ctrl_if.slave      cfg,
  output logic [1:0]          state_o,
  output logic [LW-1:0]       step_o,
  output logic                done,
  output logic                fail_pulse,
  output logic                locked,
  output logic [FW-1:0]       fail_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MATCH   = 2'd1,
    S_DONE    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam logic [LW-1:0]  DEPTH_L     = LW'(DEPTH);
  localparam logic [TW-1:0]  TIMEOUT_L   = TW'(STEP_TIMEOUT);
  localparam logic [FW-1:0]  MAX_FAILS_L = FW'(MAX_FAILS);
  localparam logic [LCW-1:0] LOCK_LAST_L = LCW'(LOCKOUT_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [LW-1:0]              step_q, step_d, step_next;
  logic [TW-1:0]              timer_q, timer_d;
  logic [FW-1:0]              fail_cnt_q, fail_cnt_d;
  logic [LCW-1:0]             lock_cnt_q, lock_cnt_d;
  logic [LW-1:0]              len_q, len_d;
  logic [DEPTH-1:0][IN_W-1:0] mask_q, mask_d;
  logic [DEPTH-1:0][IN_W-1:0] val_q, val_d;
  logic [IN_W-1:0]            smp_q, smp_d;
  logic                       done_q, done_d;
  logic                       locked_q, locked_d;
  logic                       fail_pulse_q, fail_pulse_d;

  logic [DEPTH-1:0]           hit;
  logic [AW-1:0]              cur_idx, prev_idx;
  logic                       hit_cur, hit_prev;

`ifdef SEQ_LOCK_SYNC_EN
  logic [IN_W-1:0] sync1_q, sync1_d;
  logic [IN_W-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_vec;
    sync2_d = sync1_q;
    smp_d   = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  always_comb smp_d = in_vec;
`endif

  // Every entry is compared in parallel; the FSM only picks step k and k-1.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      hit[j] = ((smp_q & mask_q[j]) == (val_q[j] & mask_q[j]));
    end
    cur_idx  = step_q[AW-1:0];
    prev_idx = cur_idx - AW'(1);
    hit_cur  = hit[cur_idx];
    hit_prev = hit[prev_idx];
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    timer_d      = timer_q;
    fail_cnt_d   = fail_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    len_d        = len_q;
    mask_d       = mask_q;
    val_d        = val_q;
    fail_pulse_d = 1'b0;
    step_next    = step_q + LW'(1);

    case (state_q)
      S_IDLE: begin
        step_d  = '0;
        timer_d = '0;
        if (cfg.cfg_we) begin
          mask_d[cfg.cfg_addr] = cfg.cfg_mask;
          val_d[cfg.cfg_addr]  = cfg.cfg_val;
        end
        if (cfg.cfg_len_we) begin
          len_d = (cfg.cfg_len > DEPTH_L) ? DEPTH_L : cfg.cfg_len;
        end
        if (arm && (len_q != '0)) begin
          state_d = S_MATCH;
        end
      end

      S_MATCH: begin
        if (!arm) begin
          state_d = S_IDLE;
          step_d  = '0;
          timer_d = '0;
        end else if (hit_cur) begin
          step_d  = step_next;
          timer_d = '0;
          if (step_next == len_q) begin
            state_d = S_DONE;
          end
        end else if (step_q == '0) begin
          // Waiting for the first pattern: never times out, never fails.
          timer_d = '0;
        end else if (hit_prev && (timer_q != TIMEOUT_L)) begin
          timer_d = timer_q + TW'(1);
        end else begin
          fail_pulse_d = 1'b1;
          step_d       = '0;
          timer_d      = '0;
          fail_cnt_d   = fail_cnt_q + FW'(1);
          if (fail_cnt_d == MAX_FAILS_L) begin
            state_d    = S_LOCKOUT;
            lock_cnt_d = '0;
          end
        end
      end

      S_DONE: begin
        if (clear) begin
          state_d    = S_IDLE;
          step_d     = '0;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else if (!arm) begin
          state_d = S_IDLE;
          step_d  = '0;
          timer_d = '0;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST_L) begin
          state_d    = S_MATCH;
          step_d     = '0;
          timer_d    = '0;
          fail_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d   = (state_d == S_DONE);
    locked_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      len_q        <= '0;
      mask_q       <= '0;
      val_q        <= '0;
      smp_q        <= '0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      len_q        <= len_d;
      mask_q       <= mask_d;
      val_q        <= val_d;
      smp_q        <= smp_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign state_o    = state_q;
  assign step_o     = step_q;
  assign done       = done_q;
  assign locked     = locked_q;
  assign fail_pulse = fail_pulse_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Self-checking bench for seq_lock_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model of the lock.
module tb_seq_lock_ctrl;
  localparam int IN_W           = 4;
  localparam int DEPTH          = 16;
  localparam int STEP_TIMEOUT   = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 10;
  localparam int OW             = 12;
`ifdef SEQ_LOCK_SYNC_EN
  localparam int PIPE = 3;
`else
  localparam int PIPE = 1;
`endif

  logic            clk;
  logic            reset;
  logic            arm;
  logic            clear;
  logic [IN_W-1:0] in_vec;
  logic [1:0]      state_o;
  logic [4:0]      step_o;
  logic            done;
  logic            fail_pulse;
  logic            locked;
  logic [1:0]      fail_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [OW-1:0] exp_q[$];

  seq_lock_ctrl_if #(.IN_W(IN_W), .DEPTH(DEPTH)) cfg_bus ();

  seq_lock_ctrl #(
    .IN_W(IN_W), .DEPTH(DEPTH), .STEP_TIMEOUT(STEP_TIMEOUT),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear), .in_vec(in_vec),
    .cfg(cfg_bus.slave),
    .state_o(state_o), .step_o(step_o), .done(done), .fail_pulse(fail_pulse),
    .locked(locked), .fail_cnt_o(fail_cnt_o)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 matching, 2 unlocked (done), 3 locked out.
  int            m_state, m_step, m_timer, m_fails, m_lock_elapsed, m_len;
  bit            m_pulse;
  logic [IN_W-1:0] m_mask[DEPTH];
  logic [IN_W-1:0] m_val[DEPTH];
  logic [IN_W-1:0] m_pipe[$];

  function automatic bit hits(logic [IN_W-1:0] smp, int j);
    return ((smp ^ m_val[j]) & m_mask[j]) == '0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_step = 0; m_timer = 0; m_fails = 0;
    m_lock_elapsed = 0; m_len = 0; m_pulse = 0;
    for (int j = 0; j < DEPTH; j++) begin
      m_mask[j] = '0;
      m_val[j]  = '0;
    end
    m_pipe.delete();
    for (int j = 0; j < PIPE; j++) m_pipe.push_back('0);
  endtask

  task automatic model_go_idle();
    m_state = 0; m_step = 0; m_timer = 0;
  endtask

  task automatic model_edge();
    logic [IN_W-1:0] smp;
    int old_len;
    smp = m_pipe[0];
    m_pulse = 0;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        old_len = m_len;
        if (cfg_bus.cfg_we) begin
          m_mask[cfg_bus.cfg_addr] = cfg_bus.cfg_mask;
          m_val[cfg_bus.cfg_addr]  = cfg_bus.cfg_val;
        end
        if (cfg_bus.cfg_len_we) m_len = (int'(cfg_bus.cfg_len) > DEPTH) ? DEPTH : int'(cfg_bus.cfg_len);
        if (arm && old_len > 0) begin
          m_state = 1; m_step = 0; m_timer = 0;
        end
      end
      1: begin
        if (!arm) model_go_idle();
        else if (hits(smp, m_step)) begin
          m_step++;
          m_timer = 0;
          if (m_step == m_len) m_state = 2;
        end else if (m_step > 0) begin
          if (hits(smp, m_step - 1) && m_timer < STEP_TIMEOUT) m_timer++;
          else begin
            m_pulse = 1; m_step = 0; m_timer = 0; m_fails++;
            if (m_fails == MAX_FAILS) begin
              m_state = 3; m_lock_elapsed = 0;
            end
          end
        end
      end
      2: begin
        if (clear) begin
          m_fails = 0;
          model_go_idle();
        end else if (!arm) model_go_idle();
      end
      default: begin
        m_lock_elapsed++;
        if (m_lock_elapsed == LOCKOUT_CYCLES) begin
          m_state = 1; m_step = 0; m_timer = 0; m_fails = 0;
        end
      end
    endcase
    void'(m_pipe.pop_front());
    m_pipe.push_back(in_vec);
  endtask

  function automatic logic [OW-1:0] expected();
    return {2'(m_state), 5'(m_step), m_state == 2, m_state == 3, m_pulse, 2'(m_fails)};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {state_o, step_o, done, locked, fail_pulse, fail_cnt_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [IN_W-1:0] mask, input logic [IN_W-1:0] val);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_addr = 4'(addr);
    cfg_bus.cfg_mask = mask;
    cfg_bus.cfg_val  = val;
    cycle();
    cfg_bus.cfg_we   = 1'b0;
  endtask

  task automatic write_len(input int len);
    cfg_bus.cfg_len_we = 1'b1;
    cfg_bus.cfg_len    = 5'(len);
    cycle();
    cfg_bus.cfg_len_we = 1'b0;
  endtask

  task automatic load_table();
    write_entry(0, 4'b0100, 4'b0100);
    write_entry(1, 4'b1001, 4'b1001);
    write_entry(2, 4'b0100, 4'b0000);
    write_len(3);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; clear = 1'b0; in_vec = '0;
    cycle(); cycle();
    n_checks++;
    if (observed() !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected %h", observed(), 12'h0);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (observed() !== expected()) begin
      n_errors++; $display("FAIL reset_idle: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_sequence();
    load_table();
    arm = 1'b1; in_vec = 4'b0100; cycle();
    in_vec = 4'b1101; cycle();
    n_checks++;
    if ({state_o, step_o} !== {2'd1, 5'd1}) begin
      n_errors++; $display("FAIL seq_step1: got %0d/%0d expected 1/1", state_o, step_o);
    end
    in_vec = 4'b1001; cycle();
    n_checks++;
    if ({state_o, step_o} !== {2'd1, 5'd2}) begin
      n_errors++; $display("FAIL seq_step2: got %0d/%0d expected 1/2", state_o, step_o);
    end
    cycle();
    n_checks++;
    if ({state_o, step_o, done} !== {2'd2, 5'd3, 1'b1}) begin
      n_errors++; $display("FAIL seq_done: got %0d/%0d/%0d expected 2/3/1", state_o, step_o, done);
    end
    n_checks++;
    if (observed() !== expected()) begin
      n_errors++; $display("FAIL seq_model: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_fail();
    clear = 1'b1; cycle(); clear = 1'b0;
    n_checks++;
    if ({state_o, fail_cnt_o, done} !== {2'd0, 2'd0, 1'b0}) begin
      n_errors++; $display("FAIL clear_done: got %0d/%0d/%0d expected 0/0/0", state_o, fail_cnt_o, done);
    end
    in_vec = 4'b0100; cycle(); cycle();
    in_vec = 4'b0010; cycle(); cycle();
    n_checks++;
    if ({state_o, step_o, fail_pulse, fail_cnt_o} !== {2'd1, 5'd0, 1'b1, 2'd1}) begin
      n_errors++; $display("FAIL fail_pulse: got %0d/%0d/%0d/%0d expected 1/0/1/1",
                           state_o, step_o, fail_pulse, fail_cnt_o);
    end
    cycle();
    n_checks++;
    if (observed() !== expected() || fail_pulse !== 1'b0) begin
      n_errors++; $display("FAIL fail_one_cycle: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_timeout();
    in_vec = 4'b0100; cycle(); cycle();
    repeat (STEP_TIMEOUT) cycle();
    n_checks++;
    if ({step_o, fail_pulse} !== {5'd1, 1'b0}) begin
      n_errors++; $display("FAIL timeout_hold: got step %0d pulse %0d expected 1/0", step_o, fail_pulse);
    end
    cycle();
    n_checks++;
    if ({step_o, fail_pulse, fail_cnt_o} !== {5'd0, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL timeout_fail: got %0d/%0d/%0d expected 0/1/2", step_o, fail_pulse, fail_cnt_o);
    end
  endtask

  task automatic test_lockout();
    cycle();
    in_vec = 4'b0010; cycle(); cycle();
    n_checks++;
    if ({state_o, locked, fail_cnt_o} !== {2'd3, 1'b1, 2'd3}) begin
      n_errors++; $display("FAIL lockout_enter: got %0d/%0d/%0d expected 3/1/3", state_o, locked, fail_cnt_o);
    end
    for (int i = 1; i < LOCKOUT_CYCLES; i++) begin
      arm = 1'($urandom_range(0, 1)); clear = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if ({state_o, locked} !== {2'd3, 1'b1} || observed() !== expected()) begin
        n_errors++; $display("FAIL lockout_hold[%0d]: got %h expected %h", i, observed(), expected());
      end
    end
    arm = 1'b1; clear = 1'b0;
    cycle();
    n_checks++;
    if ({state_o, step_o, locked, fail_cnt_o} !== {2'd1, 5'd0, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL lockout_exit: got %h expected state 1 step 0 cnt 0", observed());
    end
  endtask

  task automatic test_cfg_guard();
    in_vec = 4'b0100; cycle(); cycle();
    in_vec = 4'b1101; cycle(); cycle();
    n_checks++;
    if (step_o !== 5'd2) begin
      n_errors++; $display("FAIL cfg_reach_step2: got %0d expected 2", step_o);
    end
    in_vec = 4'b1001;
    write_entry(2, 4'b1111, 4'b1111);
    cycle();
    n_checks++;
    if ({state_o, done} !== {2'd2, 1'b1}) begin
      n_errors++; $display("FAIL cfg_write_in_match: got %0d/%0d expected 2/1", state_o, done);
    end
    arm = 1'b0; cycle();
    n_checks++;
    if ({state_o, step_o} !== {2'd0, 5'd0}) begin
      n_errors++; $display("FAIL arm_drop: got %0d/%0d expected 0/0", state_o, step_o);
    end
    write_entry(2, 4'b1111, 4'b0110);
    arm = 1'b1; in_vec = 4'b0100; cycle();
    in_vec = 4'b1101; cycle();
    in_vec = 4'b0110; cycle(); cycle();
    n_checks++;
    if ({state_o, step_o, done} !== {2'd2, 5'd3, 1'b1} || observed() !== expected()) begin
      n_errors++; $display("FAIL cfg_new_entry: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_reset_mid();
    clear = 1'b1; cycle(); clear = 1'b0;
    in_vec = 4'b0100; cycle(); cycle();
    in_vec = 4'b1101; cycle(); cycle();
    n_checks++;
    if (step_o !== 5'd2) begin
      n_errors++; $display("FAIL mid_step2: got %0d expected 2", step_o);
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    n_checks++;
    if (observed() !== '0) begin
      n_errors++; $display("FAIL reset_mid_step: got %h expected %h", observed(), 12'h0);
    end
    arm = 1'b0;
    load_table();
    arm = 1'b1;
    for (int i = 0; i < MAX_FAILS; i++) begin
      in_vec = 4'b0100; cycle(); cycle();
      in_vec = 4'b0010; cycle(); cycle();
    end
    cycle(); cycle();
    n_checks++;
    if ({state_o, locked} !== {2'd3, 1'b1}) begin
      n_errors++; $display("FAIL mid_lockout: got %0d/%0d expected 3/1", state_o, locked);
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    n_checks++;
    if (observed() !== '0) begin
      n_errors++; $display("FAIL reset_mid_lockout: got %h expected %h", observed(), 12'h0);
    end
    repeat (3) cycle();
    n_checks++;
    if (state_o !== 2'd0) begin
      n_errors++; $display("FAIL len0_arm: got %0d expected 0", state_o);
    end
    write_len(3);
    n_checks++;
    if (state_o !== 2'd0) begin
      n_errors++; $display("FAIL len_write_idle: got %0d expected 0", state_o);
    end
    cycle();
    n_checks++;
    if ({state_o, step_o} !== {2'd1, 5'd0} && observed() === expected()) begin
      n_errors++; $display("FAIL len_then_arm: got %0d/%0d expected 1/0", state_o, step_o);
    end else if (observed() !== expected()) begin
      n_errors++; $display("FAIL len_then_arm_model: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_v;
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 499) == 0);
      arm                = ($urandom_range(0, 15) != 0);
      clear              = ($urandom_range(0, 19) == 0);
      in_vec             = 4'($urandom_range(0, 15));
      cfg_bus.cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_bus.cfg_addr   = 4'($urandom_range(0, 3));
      cfg_bus.cfg_mask   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cfg_bus.cfg_val    = 4'($urandom_range(0, 15));
      cfg_bus.cfg_len_we = ($urandom_range(0, 9) == 0);
      cfg_bus.cfg_len    = 5'($urandom_range(0, 31));
      cycle();
      exp_q.push_back(expected());
      exp_v = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp_v) begin
        n_errors++; $display("FAIL random[%0d]: got %h expected %h", i, observed(), exp_v);
      end
    end
    reset = 1'b0; cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_len_we = 1'b0;
  endtask

  // ---------------- sequencer and final report ----------------
  initial begin
    reset = 1'b1; arm = 1'b0; clear = 1'b0; in_vec = '0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_mask = '0;
    cfg_bus.cfg_val = '0; cfg_bus.cfg_len_we = 1'b0; cfg_bus.cfg_len = '0;
    model_reset();
    test_reset();
    test_sequence();
    test_fail();
    test_timeout();
    test_lockout();
    test_cfg_guard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
